mdu_hilo: RTL

MDU_HILO -- requirements
Module: mdu_hilo

---
 rtl/mdu_hilo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers: multicycle MULT/MULTU/DIV/DIVU
// and single-cycle MTHI/MTLO writes.
module mdu_hilo #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] resHI;
    logic [31:0] resLO;
    logic        keepHiLo;
    logic [63:0] opResult;

    function automatic logic [63:0] mulSigned(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        logic signed [63:0] p;
        ax = $signed({{32{a[31]}}, a});
        bx = $signed({{32{b[31]}}, b});
        p  = ax * bx;
        return p;
    endfunction

    function automatic logic [63:0] mulUnsigned(input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p;
    endfunction

    // Returns {remainder, quotient}; the most-negative / -1 case wraps to itself.
    function automatic logic [63:0] divSigned(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (b == 32'sd0) begin
            q = '0;
            r = '0;
        end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
            q = a;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] divUnsigned(input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always_comb begin
        opResult = '0;
        case (Op)
            3'd0:    opResult = mulSigned(A, B);
            3'd1:    opResult = mulUnsigned(A, B);
            3'd2:    opResult = divSigned(A, B);
            3'd3:    opResult = divUnsigned(A, B);
            default: opResult = '0;
        endcase
    end

    assign Busy = (state == RUN);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            resHI    <= '0;
            resLO    <= '0;
            keepHiLo <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                resHI    <= opResult[63:32];
                                resLO    <= opResult[31:0];
                                // Divide by zero still takes the full latency but leaves HI/LO alone.
                                keepHiLo <= Op[1] && (B == 32'd0);
                                cnt      <= Op[1] ? 5'(DIV_CYCLES) : 5'(MUL_CYCLES);
                                state    <= RUN;
                            end
                            3'd4:    HI <= A;
                            3'd5:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == 5'd1) begin
                        if (!keepHiLo) begin
                            HI <= resHI;
                            LO <= resLO;
                        end
                        Done  <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
